// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Walks an instruction through NUM_STAGES sequential stages, skipping
//   bypassed stages. It retires the instruction after the last stage that is
//   not skipped, then advances the PC by 4 or redirects it to a jump target.
//   A per-stage watchdog traps a stage that hangs into a terminal ERROR
//   state. halt_req parks the sequencer between instructions.
//
// Ports
//   clock, reset_n                 : rising-edge clock, synchronous active-low reset
//   stage_done[NUM_STAGES]         : completion of the active stage
//   stage_skip[NUM_STAGES]         : bypass request per stage (bit 0 ignored)
//   jump_enable, jump_target       : PC redirect, sampled on the retire cycle
//   halt_req                       : park after the current retire
//   stage_active/stage_index       : one-hot / binary active stage
//   stage_first_cycle              : first cycle spent in the active stage
//   pc, retire, retired_count      : instruction address, retire pulse, count
//   halted                         : parked in HALTED
//   timeout_error, timed_out_stage : sticky watchdog trap and offending stage

// Per-stage decode slice: selection of this stage and whether it is a
// candidate successor of the current stage (above it and not skipped).
module stage_sequencer_cell #(
  parameter int IDX = 0,
  parameter int IW  = 1
) (
  input  logic [IW-1:0] cur,
  input  logic          run,
  input  logic          skip,
  output logic          sel,
  output logic          active,
  output logic          elig
);
  assign sel    = (cur == IW'(IDX));
  assign active = sel & run;
  // Stage 0 can never sit above cur, so its skip bit has no effect.
  assign elig   = ~skip & (cur < IW'(IDX));
endmodule

module stage_sequencer #(
  parameter int            NUM_STAGES     = 5,
  parameter int            XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00010000,
  parameter int            TIMEOUT_CYCLES = 255,
  parameter int            CNT_WIDTH      = 32
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_STAGES-1:0]         stage_done,
  input  logic [NUM_STAGES-1:0]         stage_skip,
  input  logic                          jump_enable,
  input  logic [XLEN-1:0]               jump_target,
  input  logic                          halt_req,
  output logic [NUM_STAGES-1:0]         stage_active,
  output logic [$clog2(NUM_STAGES)-1:0] stage_index,
  output logic                          stage_first_cycle,
  output logic [XLEN-1:0]               pc,
  output logic                          retire,
  output logic [CNT_WIDTH-1:0]          retired_count,
  output logic                          halted,
  output logic                          timeout_error,
  output logic [$clog2(NUM_STAGES)-1:0] timed_out_stage
);
  localparam int IW = $clog2(NUM_STAGES);
  // The watchdog only needs to reach TIMEOUT_CYCLES-1: the trap fires on the
  // cycle that value is present with done still low.
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_ERROR} state_t;

  state_t                state;
  logic [IW-1:0]         cur;
  logic                  first_q;
  logic [WW-1:0]         wdog;

  logic                  run;
  logic [NUM_STAGES-1:0] sel, act, elig;
  logic                  done_cur;
  logic                  found;
  logic [IW-1:0]         nxt;
  logic                  wd_hit;

  assign run = (state == S_RUN);

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    stage_sequencer_cell #(.IDX(g), .IW(IW)) u_cell (
      .cur    (cur),
      .run    (run),
      .skip   (stage_skip[g]),
      .sel    (sel[g]),
      .active (act[g]),
      .elig   (elig[g])
    );
  end

  // Done of the active stage, picked through the one-hot select so a
  // non-power-of-two stage count never indexes past the vector.
  assign done_cur = |(stage_done & sel);

  // Lowest eligible stage above cur; scanning downward lets the lowest win.
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int j = NUM_STAGES - 1; j >= 1; j--) begin
      if (elig[j]) begin
        found = 1'b1;
        nxt   = IW'(j);
      end
    end
  end

  assign wd_hit = (TIMEOUT_CYCLES != 0) && (wdog == WD_LAST);

  // Gated by reset_n so a reset landing on a completing last stage never
  // shows a retire pulse.
  assign retire = reset_n & run & done_cur & ~found;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= S_RUN;
      cur             <= '0;
      first_q         <= 1'b1;
      wdog            <= '0;
      pc              <= RESET_VECTOR;
      retired_count   <= '0;
      timeout_error   <= 1'b0;
      timed_out_stage <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (done_cur) begin
            // A completed stage always hands over to a fresh stage entry,
            // even when the next stage is stage 0 again.
            wdog    <= '0;
            first_q <= 1'b1;
            if (found) begin
              cur <= nxt;
            end else begin
              cur           <= '0;
              retired_count <= retired_count + CNT_WIDTH'(1);
              pc            <= jump_enable ? {jump_target[XLEN-1:2], 2'b00}
                                           : pc + XLEN'(4);
              if (halt_req) begin
                state   <= S_HALTED;
                first_q <= 1'b0;
              end
            end
          end else if (wd_hit) begin
            state           <= S_ERROR;
            first_q         <= 1'b0;
            timeout_error   <= 1'b1;
            timed_out_stage <= cur;
          end else begin
            wdog    <= wdog + WW'(1);
            first_q <= 1'b0;
          end
        end
        S_HALTED: begin
          if (!halt_req) begin
            state   <= S_RUN;
            cur     <= '0;
            first_q <= 1'b1;
            wdog    <= '0;
          end
        end
        default: begin
          // ERROR holds everything until reset.
        end
      endcase
    end
  end

  assign stage_active      = act;
  assign stage_index       = cur;
  assign stage_first_cycle = first_q & run;
  assign halted            = (state == S_HALTED);
endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;
  localparam int NS = 5;
  localparam int IW = $clog2(NS);

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NS-1:0] stage_done, stage_skip;
  logic          jump_enable, halt_req;
  logic [31:0]   jump_target;

  logic [NS-1:0] act, w_act;
  logic [IW-1:0] idx, w_idx, tstg, w_tstg;
  logic          first, w_first, ret, w_ret, hlt, w_hlt, terr, w_terr;
  logic [31:0]   pc, w_pc, cnt, w_cnt;

  int vec = 0;
  int miss = 0;

  always #5 clock = ~clock;

  stage_sequencer u_dut (
    .clock(clock), .reset_n(reset_n), .stage_done(stage_done), .stage_skip(stage_skip),
    .jump_enable(jump_enable), .jump_target(jump_target), .halt_req(halt_req),
    .stage_active(act), .stage_index(idx), .stage_first_cycle(first), .pc(pc),
    .retire(ret), .retired_count(cnt), .halted(hlt), .timeout_error(terr),
    .timed_out_stage(tstg)
  );

  stage_sequencer #(.TIMEOUT_CYCLES(4)) u_wd (
    .clock(clock), .reset_n(reset_n), .stage_done(stage_done), .stage_skip(stage_skip),
    .jump_enable(jump_enable), .jump_target(jump_target), .halt_req(halt_req),
    .stage_active(w_act), .stage_index(w_idx), .stage_first_cycle(w_first), .pc(w_pc),
    .retire(w_ret), .retired_count(w_cnt), .halted(w_hlt), .timeout_error(w_terr),
    .timed_out_stage(w_tstg)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    stage_done = '1; stage_skip = '0; jump_enable = 0; jump_target = '0; halt_req = 0;
    do_reset();
    vec++; if (act !== 5'b00001) begin miss++; $display("FAIL rst_active got=%b exp=00001", act); end
    vec++; if (idx !== 3'd0) begin miss++; $display("FAIL rst_index got=%0d exp=0", idx); end
    vec++; if (first !== 1'b1) begin miss++; $display("FAIL rst_first got=%b exp=1", first); end
    vec++; if (pc !== 32'h10000) begin miss++; $display("FAIL rst_pc got=%h exp=00010000", pc); end
    vec++; if (cnt !== 0 || hlt !== 0 || terr !== 0 || tstg !== 0) begin
      miss++; $display("FAIL rst_flags cnt=%0d hlt=%b terr=%b tstg=%0d exp=0/0/0/0", cnt, hlt, terr, tstg);
    end
    // Reset landing on the retire cycle must not retire.
    for (int s = 0; s < 4; s++) step();
    vec++; if (ret !== 1'b1) begin miss++; $display("FAIL rst_pre_retire got=%b exp=1", ret); end
    reset_n = 1'b0;
    #1;
    vec++; if (ret !== 1'b0) begin miss++; $display("FAIL rst_retire_gated got=%b exp=0", ret); end
    step();
    vec++; if (pc !== 32'h10000 || cnt !== 0 || act !== 5'b00001) begin
      miss++; $display("FAIL rst_mid_instr pc=%h cnt=%0d act=%b exp=00010000/0/00001", pc, cnt, act);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_all_done();
    stage_done = '1; stage_skip = '0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < NS; s++) begin
        vec++; if (act !== NS'(1 << s) || idx !== IW'(s) || first !== 1'b1) begin
          miss++; $display("FAIL seq_stage i=%0d s=%0d act=%b idx=%0d first=%b", i, s, act, idx, first);
        end
        vec++; if (ret !== (s == NS - 1)) begin miss++; $display("FAIL seq_retire i=%0d s=%0d got=%b", i, s, ret); end
        vec++; if (pc !== 32'h10000 + 32'(4 * i) || cnt !== 32'(i)) begin
          miss++; $display("FAIL seq_pc i=%0d s=%0d pc=%h cnt=%0d exp=%h/%0d", i, s, pc, cnt, 32'h10000 + 32'(4 * i), i);
        end
        step();
      end
    end
    vec++; if (pc !== 32'h1000c || cnt !== 3) begin miss++; $display("FAIL seq_end pc=%h cnt=%0d exp=0001000c/3", pc, cnt); end
  endtask

  task automatic test_skip();
    int stg[3] = '{0, 2, 4};
    stage_done = '1; stage_skip = 5'b01010;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        vec++; if (act !== NS'(1 << stg[k]) || ret !== (k == 2)) begin
          miss++; $display("FAIL skip_seq i=%0d k=%0d act=%b ret=%b exp_stage=%0d", i, k, act, ret, stg[k]);
        end
        step();
      end
    end
    vec++; if (cnt !== 2 || pc !== 32'h10008) begin miss++; $display("FAIL skip_end cnt=%0d pc=%h exp=2/00010008", cnt, pc); end
    stage_skip = '0;
  endtask

  task automatic test_delay();
    stage_done = 5'b11011; stage_skip = '0;
    do_reset();
    step(); step();
    for (int c = 0; c < 8; c++) begin
      if (c == 7) stage_done = '1;
      #1;
      vec++; if (act !== 5'b00100 || first !== (c == 0) || ret !== 1'b0) begin
        miss++; $display("FAIL delay_hold c=%0d act=%b first=%b ret=%b", c, act, first, ret);
      end
      step();
    end
    vec++; if (act !== 5'b01000 || first !== 1'b1) begin miss++; $display("FAIL delay_next act=%b first=%b exp=01000/1", act, first); end
  endtask

  task automatic test_jump();
    stage_done = '1; stage_skip = '0;
    do_reset();
    jump_enable = 1'b1; jump_target = 32'h20003;
    for (int s = 0; s < 4; s++) step();
    vec++; if (pc !== 32'h10000) begin miss++; $display("FAIL jump_nonretire pc=%h exp=00010000", pc); end
    step();
    vec++; if (pc !== 32'h20000 || cnt !== 1) begin miss++; $display("FAIL jump_taken pc=%h cnt=%0d exp=00020000/1", pc, cnt); end
    jump_enable = 1'b0; jump_target = 32'hdeadbeef;
    for (int s = 0; s < NS; s++) step();
    vec++; if (pc !== 32'h20004 || cnt !== 2) begin miss++; $display("FAIL jump_after pc=%h cnt=%0d exp=00020004/2", pc, cnt); end
  endtask

  task automatic test_halt();
    stage_done = '1; stage_skip = '0;
    do_reset();
    step(); step();
    halt_req = 1'b1;
    #1;
    vec++; if (ret !== 1'b0 || act !== 5'b00100) begin miss++; $display("FAIL halt_mid ret=%b act=%b", ret, act); end
    step(); step();
    vec++; if (ret !== 1'b1 || hlt !== 1'b0) begin miss++; $display("FAIL halt_retire ret=%b hlt=%b exp=1/0", ret, hlt); end
    step();
    vec++; if (hlt !== 1'b1 || act !== 5'b00000 || pc !== 32'h10004 || cnt !== 1) begin
      miss++; $display("FAIL halt_parked hlt=%b act=%b pc=%h cnt=%0d", hlt, act, pc, cnt);
    end
    step(); step();
    vec++; if (hlt !== 1'b1 || ret !== 1'b0 || cnt !== 1) begin miss++; $display("FAIL halt_stay hlt=%b ret=%b cnt=%0d", hlt, ret, cnt); end
    halt_req = 1'b0;
    step();
    vec++; if (hlt !== 1'b0 || act !== 5'b00001 || first !== 1'b1) begin
      miss++; $display("FAIL halt_release hlt=%b act=%b first=%b", hlt, act, first);
    end
  endtask

  task automatic test_timeout();
    stage_done = 5'b00001; stage_skip = '0;
    do_reset();
    step();
    for (int c = 0; c < 4; c++) begin
      vec++; if (w_act !== 5'b00010 || w_terr !== 1'b0) begin miss++; $display("FAIL wd_hold c=%0d act=%b terr=%b", c, w_act, w_terr); end
      step();
    end
    vec++; if (w_terr !== 1'b1 || w_tstg !== 3'd1 || w_act !== 5'b00000 || w_pc !== 32'h10000) begin
      miss++; $display("FAIL wd_trip terr=%b tstg=%0d act=%b pc=%h", w_terr, w_tstg, w_act, w_pc);
    end
    stage_done = '1;
    step(); step(); step();
    vec++; if (w_pc !== 32'h10000 || w_cnt !== 0 || w_ret !== 1'b0 || w_terr !== 1'b1 || w_act !== 0) begin
      miss++; $display("FAIL wd_frozen pc=%h cnt=%0d ret=%b terr=%b act=%b", w_pc, w_cnt, w_ret, w_terr, w_act);
    end
    stage_done = 5'b00001;
    reset_n = 1'b0;
    step();
    vec++; if (w_terr !== 1'b0 || w_tstg !== 0 || w_act !== 5'b00001 || w_first !== 1'b1 || w_pc !== 32'h10000) begin
      miss++; $display("FAIL wd_reset terr=%b tstg=%0d act=%b first=%b pc=%h", w_terr, w_tstg, w_act, w_first, w_pc);
    end
    reset_n = 1'b1;
    step();
    step(); step(); step();
    stage_done = 5'b00011;
    step();
    vec++; if (w_terr !== 1'b0 || w_act !== 5'b00100) begin
      miss++; $display("FAIL wd_boundary terr=%b act=%b exp=0/00100", w_terr, w_act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; stage_done = '0; stage_skip = '0;
    jump_enable = 1'b0; jump_target = '0; halt_req = 1'b0;
    test_reset();
    test_all_done();
    test_skip();
    test_delay();
    test_jump();
    test_halt();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
